piso_stuff_serializer: RTL

Parametrised successor to the 8-bit PISO shifter. Serialises a stream of DATA_W-bit words into a single bit stream, advancing one bit per shift_enable strobe, with selectable bit order and optional USB-style bit stuffing. A one-word holding register with a ready/valid handshake keeps back-to-back words contiguous. Sits in the TX path between the packet/byte layer and the NRZI encoder.

---
 rtl/usb_bit_pkg.sv | 14 +
 rtl/piso_stuff_serializer_if.sv | 16 +
 rtl/stuff_counter.sv | 41 ++++
 rtl/piso_stuff_serializer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/usb_bit_pkg.sv
// Shared definitions for the USB bit-level TX/RX path: serializer state
// encoding and the standard bit-stuffing run length.
package usb_bit_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SHIFT      = 2'd1,
      STUFF_TAIL = 2'd2
   } ser_state_e;

   localparam int USB_STUFF_RUN = 6;
   localparam int ONES_W        = 4;

endpackage

// File: rtl/piso_stuff_serializer_if.sv
// Word-level ready/valid input bus of the serializer.
// Handshake: a word (in_data, in_last) transfers on a rising clock edge where
// in_valid && in_ready are both 1; in_valid with in_ready low has no effect.
interface piso_stuff_serializer_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;

   modport master (output in_data, output in_valid, output in_last, input in_ready);
   modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/stuff_counter.sv
// Counts consecutive 1 bits, saturating at RUN; flags when a stuff bit is due.
// Shared between the TX stuffer and the RX destuffer.
module stuff_counter
   import usb_bit_pkg::*;
#(
   parameter int RUN = USB_STUFF_RUN
) (
   input  logic clk,
   input  logic nRST,
   input  logic clr_i,
   input  logic upd_i,
   input  logic one_i,
   output logic stuff_now_o,
   output logic full_next_o
);

   localparam logic [ONES_W-1:0] RUN_C = ONES_W'(RUN);

   logic [ONES_W-1:0] cnt_q;
   logic [ONES_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (upd_i) begin
         if (!one_i)              cnt_d = '0;
         else if (cnt_q >= RUN_C) cnt_d = RUN_C;
         else                     cnt_d = cnt_q + ONES_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign stuff_now_o = (cnt_q == RUN_C);
   assign full_next_o = (cnt_d == RUN_C);

endmodule

// File: rtl/piso_stuff_serializer.sv
// Word-to-bit serializer with a one-word holding register, selectable bit
// order and optional bit stuffing; one output bit per shift_enable strobe.
module piso_stuff_serializer
   import usb_bit_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LSB_FIRST = 1,
   parameter int STUFF_EN  = 1,
   parameter int STUFF_RUN = USB_STUFF_RUN
) (
   input  logic                    clk,
   input  logic                    nRST,
   input  logic                    shift_enable,
   piso_stuff_serializer_if.slave  in_if,
   output logic                    serial_out,
   output logic                    bit_valid,
   output logic                    stuff_bit,
   output logic                    busy,
   output logic                    done,
   output logic                    underrun,
   output ser_state_e              state_dbg_o
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
   logic              hold_full_q, hold_full_d, hold_last_q, hold_last_d;
   logic              word_last_q, word_last_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              in_ready_q, busy_q;
   logic              serial_q, serial_d, bit_valid_q, bit_valid_d;
   logic              stuff_bit_q, stuff_bit_d, done_q, done_d, underrun_q, underrun_d;

   logic accept, load_idle, reload, take_hold;
   logic emit_run_stuff, emit_tail, emit_data, word_end, end_stuff, data_bit;
   logic stuff_now, full_next;

   assign accept         = in_if.in_valid && in_ready_q;
   assign data_bit       = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
   assign emit_run_stuff = (state_q == SHIFT) && shift_enable && (STUFF_EN != 0) && stuff_now;
   assign emit_data      = (state_q == SHIFT) && shift_enable && !emit_run_stuff;
   assign emit_tail      = (state_q == STUFF_TAIL) && shift_enable;
   assign word_end       = emit_data && (bit_cnt_q == LAST_IDX);
   assign end_stuff      = word_end && word_last_q && (STUFF_EN != 0) && full_next;
   assign load_idle      = (state_q == IDLE) && hold_full_q;
   // The next word continues the same run of 1s, so the counter is not cleared here.
   assign reload         = word_end && !word_last_q && hold_full_q;
   assign take_hold      = load_idle || reload;

   stuff_counter #(.RUN(STUFF_RUN)) u_stuff_counter (
      .clk         (clk),
      .nRST        (nRST),
      .clr_i       (load_idle || emit_run_stuff || emit_tail),
      .upd_i       (emit_data),
      .one_i       (data_bit),
      .stuff_now_o (stuff_now),
      .full_next_o (full_next)
   );

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         hold_last_q <= 1'b0;
         shift_q     <= '0;
         word_last_q <= 1'b0;
         bit_cnt_q   <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         serial_q    <= 1'b0;
         bit_valid_q <= 1'b0;
         stuff_bit_q <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         hold_last_q <= hold_last_d;
         shift_q     <= shift_d;
         word_last_q <= word_last_d;
         bit_cnt_q   <= bit_cnt_d;
         in_ready_q  <= !hold_full_d;
         busy_q      <= (state_d != IDLE);
         serial_q    <= serial_d;
         bit_valid_q <= bit_valid_d;
         stuff_bit_q <= stuff_bit_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (hold_full_q) state_d = SHIFT;
         SHIFT: begin
            if (word_end) begin
               if (end_stuff)   state_d = STUFF_TAIL;
               else if (!reload) state_d = IDLE;
            end
         end
         STUFF_TAIL: if (shift_enable) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      hold_last_d = hold_last_q;
      shift_d     = shift_q;
      word_last_d = word_last_q;
      bit_cnt_d   = bit_cnt_q;
      serial_d    = serial_q;
      bit_valid_d = 1'b0;
      stuff_bit_d = 1'b0;
      done_d      = 1'b0;
      underrun_d  = 1'b0;

      if (take_hold) begin
         shift_d     = hold_q;
         word_last_d = hold_last_q;
         bit_cnt_d   = '0;
         hold_full_d = 1'b0;
      end else if (emit_data) begin
         shift_d   = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      // Refill after the move so a simultaneous accept lands in the emptied slot.
      if (accept) begin
         hold_d      = in_if.in_data;
         hold_last_d = in_if.in_last;
         hold_full_d = 1'b1;
      end

      if (emit_data) begin
         serial_d    = data_bit;
         bit_valid_d = 1'b1;
      end
      if (emit_run_stuff || emit_tail) begin
         serial_d    = 1'b0;
         bit_valid_d = 1'b1;
         stuff_bit_d = 1'b1;
      end
      if (emit_tail || (word_end && word_last_q && !end_stuff)) done_d = 1'b1;
      if (word_end && !word_last_q && !hold_full_q) underrun_d = 1'b1;
   end

   assign in_if.in_ready = in_ready_q;
   assign busy           = busy_q;
   assign serial_out     = serial_q;
   assign bit_valid      = bit_valid_q;
   assign stuff_bit      = stuff_bit_q;
   assign done           = done_q;
   assign underrun       = underrun_q;
   assign state_dbg_o    = state_q;

endmodule
